// File: rtl/pipe_reg_chain_pkg.sv
// pipe_reg_chain_pkg: shared limits for the generic pipeline register chain.
package pipe_reg_chain_pkg;
    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 8;
endpackage

// File: rtl/pipe_reg_chain_stage_slot.sv
// pipe_stage_slot: one pipeline stage holding valid, ctrl and data with flush/hold/bubble commands.
module pipe_stage_slot #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 64,
    parameter bit FLUSH_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    input  logic              flush,
    input  logic              hold,
    input  logic              bubble,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    logic take;

    assign take = up_valid && !bubble;

    // A bubble keeps its stale data so only valid/ctrl need clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (FLUSH_DATA) data <= '0;
        end else if (!hold) begin
            valid <= take;
            ctrl  <= take ? up_ctrl : '0;
            if (!bubble) data <= up_data;
        end
    end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH pipeline registers with per-stage stall/flush and a saturating stall counter.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int CTRL_W     = 16,
    parameter int DEPTH      = 4,
    parameter bit FLUSH_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    input  logic [DEPTH-1:0]        stall,
    input  logic [DEPTH-1:0]        flush,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH*CTRL_W-1:0] stage_ctrl,
    output logic [DEPTH*DATA_W-1:0] stage_data,
    output logic                    out_valid,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [DATA_W-1:0]       out_data,
    output logic [CNT_W-1:0]        stall_cnt
);
    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] bubble;

    if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH must be in 1..8");
    end

    // A stall anywhere downstream freezes every earlier stage.
    always_comb begin
        hold = stall;
        for (int i = DEPTH - 2; i >= 0; i--) hold[i] = hold[i] | hold[i+1];
    end

    assign bubble   = hold << 1;
    assign in_ready = ~hold[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              up_valid;
        logic [CTRL_W-1:0] up_ctrl;
        logic [DATA_W-1:0] up_data;
        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_ctrl  = in_ctrl;
            assign up_data  = in_data;
        end else begin : g_body
            assign up_valid = stage_valid[i-1];
            assign up_ctrl  = stage_ctrl[(i-1)*CTRL_W +: CTRL_W];
            assign up_data  = stage_data[(i-1)*DATA_W +: DATA_W];
        end
        pipe_stage_slot #(
            .CTRL_W     (CTRL_W),
            .DATA_W     (DATA_W),
            .FLUSH_DATA (FLUSH_DATA)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .up_valid (up_valid),
            .up_ctrl  (up_ctrl),
            .up_data  (up_data),
            .flush    (flush[i]),
            .hold     (hold[i]),
            .bubble   (bubble[i]),
            .valid    (stage_valid[i]),
            .ctrl     (stage_ctrl[i*CTRL_W +: CTRL_W]),
            .data     (stage_data[i*DATA_W +: DATA_W])
        );
    end

    assign out_valid = stage_valid[DEPTH-1];
    assign out_ctrl  = stage_ctrl[(DEPTH-1)*CTRL_W +: CTRL_W];
    assign out_data  = stage_data[(DEPTH-1)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (hold[0] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: scoreboard bench for pipe_reg_chain with DEPTH=4 and a 4-bit stall counter.
module tb_pipe_reg_chain;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int DW    = 64;
    localparam int NW    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [CW-1:0]        in_ctrl;
    logic [DW-1:0]        in_data;
    logic                 in_ready;
    logic [DEPTH-1:0]     stall;
    logic [DEPTH-1:0]     flush;
    logic [DEPTH-1:0]     stage_valid;
    logic [DEPTH*CW-1:0]  stage_ctrl;
    logic [DEPTH*DW-1:0]  stage_data;
    logic                 out_valid;
    logic [CW-1:0]        out_ctrl;
    logic [DW-1:0]        out_data;
    logic [NW-1:0]        stall_cnt;

    int            tests_run = 0;
    int            fails = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] nd;
    logic [DW-1:0] e;
    logic [NW-1:0] exp_cnt;

    pipe_reg_chain #(
        .DATA_W     (DW),
        .CTRL_W     (CW),
        .DEPTH      (DEPTH),
        .FLUSH_DATA (1'b0),
        .CNT_W      (NW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ctrl     (in_ctrl),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .stall       (stall),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_ctrl  (stage_ctrl),
        .stage_data  (stage_data),
        .out_valid   (out_valid),
        .out_ctrl    (out_ctrl),
        .out_data    (out_data),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
        return {d[7:0], 8'hFF};
    endfunction

    // Drives the next item, advances one edge, records captures and the expected stall count.
    task automatic cycle();
        logic cap;
        in_data = nd;
        in_ctrl = ctrl_of(nd);
        cap = in_valid && !rst && !(|stall) && !flush[0];
        @(posedge clk);
        if (cap) begin
            q.push_back(nd);
            nd = nd + 1;
        end
        exp_cnt = rst ? '0 : ((|stall) && exp_cnt != '1) ? exp_cnt + 1'b1 : exp_cnt;
        #1;
    endtask

    task automatic test_reset_flow();
        rst = 1'b1; in_valid = 1'b0; stall = '0; flush = '0;
        nd = 64'h10; exp_cnt = '0;
        repeat (2) cycle();
        tests_run++;
        if ({stage_valid, stage_ctrl, stage_data, stall_cnt, out_valid, out_ctrl, out_data} !== '0) begin
            fails++;
            $display("FAIL reset_zero: valid=%b ctrl=%h cnt=%0d out_data=%h, want all 0", stage_valid, stage_ctrl, stall_cnt, out_data);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
        rst = 1'b0; in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            tests_run++;
            if (k < 4) begin
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL flow_latency k=%0d: out_valid=%b want 0", k, out_valid);
                end
            end else begin
                e = q.size() ? q.pop_front() : 'x;
                if (out_valid !== 1'b1 || out_data !== e || out_ctrl !== ctrl_of(e)) begin
                    fails++;
                    $display("FAIL flow_out k=%0d: valid=%b data=%h ctrl=%h want data=%h ctrl=%h", k, out_valid, out_data, out_ctrl, e, ctrl_of(e));
                end
            end
        end
    endtask

    task automatic test_load_use();
        logic exp_v[3] = '{1'b0, 1'b1, 1'b1};
        stall = 4'b0010;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL lu_ready: in_ready=%b want 0", in_ready);
        end
        cycle();
        e = q.size() ? q.pop_front() : 'x;
        tests_run++;
        if (stage_valid !== 4'b1011 || stage_ctrl[2*CW +: CW] !== '0 ||
            stage_data[0 +: DW] !== nd - 1 || stage_data[DW +: DW] !== nd - 2) begin
            fails++;
            $display("FAIL lu_stages: valid=%b ctrl2=%h d0=%h d1=%h want 1011 0000 %h %h", stage_valid, stage_ctrl[2*CW +: CW], stage_data[0 +: DW], stage_data[DW +: DW], nd - 1, nd - 2);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== e || stall_cnt !== exp_cnt || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL lu_out: valid=%b data=%h cnt=%0d want 1 %h %0d", out_valid, out_data, stall_cnt, e, exp_cnt);
        end
        stall = '0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests_run++;
            if (exp_v[k]) begin
                e = q.size() ? q.pop_front() : 'x;
                if (out_valid !== 1'b1 || out_data !== e || out_ctrl !== ctrl_of(e)) begin
                    fails++;
                    $display("FAIL lu_drain k=%0d: valid=%b data=%h want 1 %h", k, out_valid, out_data, e);
                end
            end else if (out_valid !== 1'b0 || out_ctrl !== '0) begin
                fails++;
                $display("FAIL lu_bubble k=%0d: valid=%b ctrl=%h want 0 0000", k, out_valid, out_ctrl);
            end
        end
    endtask

    task automatic test_flush();
        flush = 4'b0011; in_valid = 1'b0;
        cycle();
        e = q.size() ? q.pop_front() : 'x;
        tests_run++;
        if (stage_valid !== 4'b1100 || stage_ctrl[0 +: 2*CW] !== '0 ||
            stage_data[0 +: DW] !== nd - 1 || stage_data[DW +: DW] !== nd - 2) begin
            fails++;
            $display("FAIL fl_stages: valid=%b ctrl01=%h d0=%h d1=%h want 1100 0 %h %h", stage_valid, stage_ctrl[0 +: 2*CW], stage_data[0 +: DW], stage_data[DW +: DW], nd - 1, nd - 2);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== e || stage_data[2*DW +: DW] !== nd - 2) begin
            fails++;
            $display("FAIL fl_advance: out=%b/%h d2=%h want 1/%h %h", out_valid, out_data, stage_data[2*DW +: DW], e, nd - 2);
        end
        void'(q.pop_back());
        flush = '0;
        cycle();
        e = q.size() ? q.pop_front() : 'x;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            fails++;
            $display("FAIL fl_next: valid=%b data=%h want 1 %h", out_valid, out_data, e);
        end
        cycle();
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            fails++;
            $display("FAIL fl_bubble_out: valid=%b ctrl=%h want 0 0000", out_valid, out_ctrl);
        end
    endtask

    task automatic test_flush_vs_stall();
        logic exp_v[3] = '{1'b0, 1'b1, 1'b1};
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            tests_run++;
            if (k == 3) begin
                e = q.size() ? q.pop_front() : 'x;
                if (out_valid !== 1'b1 || out_data !== e) begin
                    fails++;
                    $display("FAIL fs_fill: valid=%b data=%h want 1 %h", out_valid, out_data, e);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL fs_fill k=%0d: valid=%b want 0", k, out_valid);
            end
        end
        stall = 4'b0100; flush = 4'b0100;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL fs_ready: in_ready=%b want 0", in_ready);
        end
        cycle();
        tests_run++;
        if (stage_valid !== 4'b0011 || out_ctrl !== '0 || stage_ctrl[2*CW +: CW] !== '0 ||
            stage_data[0 +: DW] !== nd - 1 || stage_data[DW +: DW] !== nd - 2 ||
            stage_ctrl[0 +: CW] !== ctrl_of(nd - 1) || stall_cnt !== exp_cnt) begin
            fails++;
            $display("FAIL fs_stages: valid=%b d0=%h d1=%h cnt=%0d want 0011 %h %h %0d", stage_valid, stage_data[0 +: DW], stage_data[DW +: DW], stall_cnt, nd - 1, nd - 2, exp_cnt);
        end
        void'(q.pop_front());
        stall = '0; flush = '0; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests_run++;
            if (exp_v[k]) begin
                e = q.size() ? q.pop_front() : 'x;
                if (out_valid !== 1'b1 || out_data !== e) begin
                    fails++;
                    $display("FAIL fs_drain k=%0d: valid=%b data=%h want 1 %h", k, out_valid, out_data, e);
                end
            end else if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL fs_drain k=%0d: valid=%b want 0", k, out_valid);
            end
        end
        tests_run++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL fs_leftover: %0d items never emerged, want 0", q.size());
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b1;
        q.delete();
        repeat (4) cycle();
        e = q.size() ? q.pop_front() : 'x;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== e || stall_cnt !== '0) begin
            fails++;
            $display("FAIL sat_fill: valid=%b data=%h cnt=%0d want 1 %h 0", out_valid, out_data, stall_cnt, e);
        end
        stall = 4'b1000;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            tests_run++;
            if (stall_cnt !== exp_cnt || out_valid !== 1'b1 || out_data !== e || stage_valid !== 4'hF) begin
                fails++;
                $display("FAIL sat_hold k=%0d: cnt=%0d out=%b/%h valid=%b want %0d 1/%h 1111", k, stall_cnt, out_valid, out_data, stage_valid, exp_cnt, e);
            end
        end
        tests_run++;
        if (stall_cnt !== 4'hF) begin
            fails++;
            $display("FAIL sat_final: cnt=%0d want 15", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 4'hF; rst = 1'b1;
        cycle();
        tests_run++;
        if (stage_valid !== '0 || stage_ctrl !== '0 || stage_data !== '0 || stall_cnt !== '0) begin
            fails++;
            $display("FAIL rst_stall: valid=%b ctrl=%h cnt=%0d want 0 0 0", stage_valid, stage_ctrl, stall_cnt);
        end
        rst = 1'b0; stall = '0;
        q.delete();
    endtask

    initial begin
        test_reset_flow();
        test_load_use();
        test_flush();
        test_flush_vs_stall();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
